// File: rtl/imem_port_arbiter.sv
// Two-port arbiter in front of the single-ported instruction ROM: CPU fetch (F) has
// priority, a starvation counter guarantees the debug reader (D) eventually wins.
module imem_port_arbiter #(
    parameter int AW     = 6,
    parameter int DW     = 32,
    parameter int STARVE = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [DW-1:0] f_rdata,
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_instr
);

    typedef enum logic {F_PRI, D_PRI} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_F, OWN_D} owner_t;

    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE - 1);

    state_t     state, state_nxt;
    logic [3:0] starve_cnt, starve_nxt;
    owner_t     tag1;
    logic       contested;

    assign contested = f_req & d_req;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= F_PRI;
            starve_cnt <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latches).
        state_nxt  = state;
        starve_nxt = starve_cnt;
        case (state)
            F_PRI: begin
                if (contested) begin
                    starve_nxt = (starve_cnt == 4'hF) ? starve_cnt : starve_cnt + 4'd1;
                    if (starve_cnt >= STARVE_LIMIT) state_nxt = D_PRI;
                end else if (d_req) begin
                    starve_nxt = '0;
                end
            end
            D_PRI: begin
                // Any D request wins here; a lone F is still served without a bubble.
                if (d_req) begin
                    state_nxt  = F_PRI;
                    starve_nxt = '0;
                end
            end
            default: state_nxt = F_PRI;
        endcase
    end

    // Grant outputs, suppressed while reset is asserted
    always_comb begin
        f_gnt = 1'b0;
        d_gnt = 1'b0;
        if (reset_n) begin
            if (contested) begin
                d_gnt = (state == D_PRI);
                f_gnt = (state != D_PRI);
            end else begin
                f_gnt = f_req;
                d_gnt = d_req;
            end
        end
    end

    // Two-stage read pipeline: address/owner capture, then data return to the owner
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the read-data registers are reset too because their reset value is
            // observable at the ports; dropping the owner tag discards in-flight reads.
            mem_addr <= '0;
            tag1     <= OWN_NONE;
            f_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            f_rdata  <= '0;
            d_rdata  <= '0;
        end else begin
            if (f_gnt) begin
                mem_addr <= f_addr;
                tag1     <= OWN_F;
            end else if (d_gnt) begin
                mem_addr <= d_addr;
                tag1     <= OWN_D;
            end else begin
                tag1     <= OWN_NONE;
            end
            f_rvalid <= (tag1 == OWN_F);
            d_rvalid <= (tag1 == OWN_D);
            if (tag1 == OWN_F) f_rdata <= mem_instr;
            if (tag1 == OWN_D) d_rdata <= mem_instr;
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a transaction-level model with a return queue.
module tb_imem_port_arbiter;

    localparam int AW     = 6;
    localparam int DW     = 32;
    localparam int STARVE = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          f_req = 1'b0, d_req = 1'b0;
    logic [AW-1:0] f_addr = '0, d_addr = '0;
    logic          f_gnt, d_gnt, f_rvalid, d_rvalid;
    logic [DW-1:0] f_rdata, d_rdata, mem_instr;
    logic [AW-1:0] mem_addr;

    imem_port_arbiter #(.AW(AW), .DW(DW), .STARVE(STARVE)) dut (
        .clk(clk), .reset_n(reset_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_instr(mem_instr)
    );

    assign mem_instr = 32'hA5A5_0000 | DW'(mem_addr);
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pending returns with due cycle, priority flag, loss counter
    typedef struct {bit is_d; logic [AW-1:0] addr; int due;} ret_t;
    ret_t          pend[$];
    int            cyc = 0;
    bit            m_dpri = 0;
    int            m_losses = 0;
    logic [AW-1:0] m_mem_addr = '0;
    logic [DW-1:0] m_f_data = '0, m_d_data = '0;
    bit            m_gf, m_gd;
    string         gnt_log;

    function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
        return 32'hA5A5_0000 | DW'(a);
    endfunction

    task automatic model_clear();
        pend.delete();
        m_dpri = 0; m_losses = 0; m_mem_addr = '0;
        m_f_data = '0; m_d_data = '0;
    endtask

    // One clock cycle: inputs are already driven (just after a falling edge)
    task automatic cycle();
        bit ef_v, ed_v;
        logic [AW-1:0] fa, da;
        #1;
        fa = f_addr; da = d_addr;
        m_gf = 0; m_gd = 0;
        if (f_req && d_req) begin
            if (m_dpri) m_gd = 1; else m_gf = 1;
        end else begin
            m_gf = f_req; m_gd = d_req;
        end
        ef_v = 0; ed_v = 0;
        while (pend.size() > 0 && pend[0].due <= cyc) begin
            if (pend[0].due == cyc) begin
                if (pend[0].is_d) begin ed_v = 1; m_d_data = rom(pend[0].addr); end
                else begin ef_v = 1; m_f_data = rom(pend[0].addr); end
            end
            void'(pend.pop_front());
        end
        checks++; if (f_gnt !== m_gf) begin errors++; $display("FAIL f_gnt cyc %0d: got %b exp %b", cyc, f_gnt, m_gf); end
        checks++; if (d_gnt !== m_gd) begin errors++; $display("FAIL d_gnt cyc %0d: got %b exp %b", cyc, d_gnt, m_gd); end
        checks++; if (f_rvalid !== ef_v) begin errors++; $display("FAIL f_rvalid cyc %0d: got %b exp %b", cyc, f_rvalid, ef_v); end
        checks++; if (d_rvalid !== ed_v) begin errors++; $display("FAIL d_rvalid cyc %0d: got %b exp %b", cyc, d_rvalid, ed_v); end
        checks++; if (f_rdata !== m_f_data) begin errors++; $display("FAIL f_rdata cyc %0d: got %h exp %h", cyc, f_rdata, m_f_data); end
        checks++; if (d_rdata !== m_d_data) begin errors++; $display("FAIL d_rdata cyc %0d: got %h exp %h", cyc, d_rdata, m_d_data); end
        checks++; if (mem_addr !== m_mem_addr) begin errors++; $display("FAIL mem_addr cyc %0d: got %h exp %h", cyc, mem_addr, m_mem_addr); end
        gnt_log = {gnt_log, m_gf ? "F" : (m_gd ? "D" : "-")};
        @(posedge clk);
        if (m_gf) begin pend.push_back('{0, fa, cyc + 2}); m_mem_addr = fa; end
        if (m_gd) begin pend.push_back('{1, da, cyc + 2}); m_mem_addr = da; end
        if (f_req && d_req) begin
            if (m_gd) begin m_dpri = 0; m_losses = 0; end
            else begin
                m_losses = (m_losses < 15) ? m_losses + 1 : 15;
                if (m_losses >= STARVE) m_dpri = 1;
            end
        end else if (m_gd) begin
            m_dpri = 0; m_losses = 0;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; f_req = 0; d_req = 0;
        @(negedge clk);
        reset_n = 1'b1;
        model_clear();
    endtask

    task automatic idle(input int n);
        f_req = 0; d_req = 0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0; f_req = 1; d_req = 1;
        #1;
        checks++; if ({f_gnt, d_gnt, f_rvalid, d_rvalid} !== 4'b0) begin errors++; $display("FAIL reset_ctl: got %b exp 0000", {f_gnt, d_gnt, f_rvalid, d_rvalid}); end
        checks++; if ({f_rdata, d_rdata} !== '0) begin errors++; $display("FAIL reset_rdata: got %h exp 0", {f_rdata, d_rdata}); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %h exp 0", mem_addr); end
        @(negedge clk);
        reset_n = 1'b1; f_req = 0; d_req = 0;
        model_clear();
        idle(2);
    endtask

    task automatic test_f_single();
        f_req = 1; f_addr = 6'h05;
        cycle();
        idle(3);
        checks++; if (m_f_data !== 32'hA5A5_0005) begin errors++; $display("FAIL f_single_data: got %h exp a5a50005", m_f_data); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            f_req = 1; f_addr = AW'(i);
            cycle();
        end
        idle(3);
    endtask

    task automatic test_starvation();
        do_reset();
        gnt_log = "";
        f_req = 1; d_req = 1; f_addr = 6'h11; d_addr = 6'h20;
        for (int i = 0; i < 15; i++) begin
            cycle();
            if (m_gd) d_addr = d_addr + 1;
            if (m_gf) f_addr = f_addr + 1;
        end
        checks++; if (gnt_log != "FFFFDFFFFDFFFFD") begin errors++; $display("FAIL starve_pattern: got %s exp FFFFDFFFFDFFFFD", gnt_log); end
        idle(3);
    endtask

    task automatic test_d_only();
        d_req = 1; d_addr = 6'h3F;
        cycle();
        idle(3);
        checks++; if (m_d_data !== 32'hA5A5_003F) begin errors++; $display("FAIL d_only_data: got %h exp a5a5003f", m_d_data); end
        gnt_log = "";
        f_req = 1; d_req = 1;
        for (int i = 0; i < 5; i++) cycle();
        checks++; if (gnt_log != "FFFFD") begin errors++; $display("FAIL d_only_state: got %s exp FFFFD", gnt_log); end
        idle(3);
    endtask

    task automatic test_reset_mid();
        do_reset();
        f_req = 1; f_addr = 6'h10;
        cycle();
        reset_n = 1'b0;
        #1;
        checks++; if ({f_gnt, f_rvalid, d_rvalid} !== 3'b0) begin errors++; $display("FAIL midrst_ctl: got %b exp 000", {f_gnt, f_rvalid, d_rvalid}); end
        checks++; if (mem_addr !== '0 || f_rdata !== '0) begin errors++; $display("FAIL midrst_regs: got %h/%h exp 0/0", mem_addr, f_rdata); end
        @(negedge clk);
        reset_n = 1'b1; f_req = 0;
        model_clear();
        idle(3);
        f_req = 1; f_addr = 6'h22;
        cycle();
        idle(3);
        checks++; if (m_f_data !== 32'hA5A5_0022) begin errors++; $display("FAIL midrst_data: got %h exp a5a50022", m_f_data); end
    endtask

    task automatic test_f_in_dpri();
        do_reset();
        gnt_log = "";
        f_req = 1; d_req = 1; f_addr = 6'h01; d_addr = 6'h02;
        for (int i = 0; i < 4; i++) cycle();
        d_req = 0; f_addr = 6'h03;
        cycle();
        d_req = 1; f_addr = 6'h04;
        cycle();
        checks++; if (gnt_log != "FFFFFD") begin errors++; $display("FAIL dpri_pattern: got %s exp FFFFFD", gnt_log); end
        idle(3);
    endtask

    task automatic test_random();
        do_reset();
        m_gf = 0; m_gd = 0;
        for (int i = 0; i < 400; i++) begin
            if (!f_req || m_gf) begin f_req = $urandom_range(0, 1); f_addr = AW'($urandom); end
            else if ($urandom_range(0, 3) == 0) f_addr = AW'($urandom);
            if (!d_req || m_gd) begin d_req = ($urandom_range(0, 2) != 0); d_addr = AW'($urandom); end
            else if ($urandom_range(0, 3) == 0) d_addr = AW'($urandom);
            cycle();
        end
        idle(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_f_single();
        test_back_to_back();
        test_starvation();
        test_d_only();
        test_reset_mid();
        test_f_in_dpri();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
